ad2_i2c_responder: RTL and testbench
====================================

AD2_I2C_RESPONDER -- requirements
Module: ad2_i2c_responder

Interface
REQ-001 Parameter I2C_ADDR, default 7'h28, 7-bit target address the block answers to.
REQ-002 Parameter CFG_RESET, default 8'h10, configuration register value after reset.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 scl_in  input  1  I2C SCL line level, asynchronous to clk.
REQ-006 sda_in  input  1  I2C SDA line level, asynchronous to clk.
REQ-007 sda_oe  output  1  1 = pull SDA low (open-drain), 0 = release.
REQ-008 sample0..sample3  input  12 each  conversion values for channels 0..3, unsigned.
REQ-009 cfg_reg  output  8  last configuration byte written by the controller.
REQ-010 cfg_wr  output  1  one-cycle pulse when cfg_reg is updated.
REQ-011 busy  output  1  high from detected START to detected STOP.

Function
REQ-012 SCL and SDA SHALL each pass through a 2-flop synchronizer; all edge and condition detection SHALL use the synchronized values (2-cycle input latency).
REQ-013 START = SDA falling while SCL high; STOP = SDA rising while SCL high; both SHALL be recognised in any state, including mid-byte.
REQ-014 FSM states: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
REQ-015 START (or repeated START) -> ADDR, bit counter cleared, busy=1; STOP -> IDLE, sda_oe=0, busy=0.
REQ-016 Data bits SHALL be sampled on SCL rising edges, MSB first; sda_oe SHALL change only on SCL falling edges.
REQ-017 ADDR: after 8 bits, if bits[7:1]==I2C_ADDR -> ADDR_ACK, else WAIT_STOP (sda_oe stays 0).
REQ-018 ADDR_ACK: sda_oe=1 for exactly the 9th SCL clock; on following SCL fall go to WR_BYTE (R/W=0) or RD_BYTE (R/W=1).
REQ-019 WR_BYTE: after 8 bits, cfg_reg <= received byte, cfg_wr pulses one cycle, ACK driven in WR_ACK, then back to WR_BYTE for further bytes (each overwrites cfg_reg).
REQ-020 Active channel set = cfg_reg[7:4]; if all zero, channel 0 alone is active.
REQ-021 Read word = two bytes: byte0 = {2'b00, ch_id[1:0], value[11:8]}, byte1 = value[7:0].
REQ-022 The sampleN value SHALL be latched when byte0 is loaded; byte1 comes from the same latch.
REQ-023 Each read transaction SHALL start at the lowest active channel and advance to the next higher active channel after each completed word, wrapping to the lowest.
REQ-024 RD_BYTE: shift byte out, bit value 0 -> sda_oe=1, bit value 1 -> sda_oe=0; after 8 bits release SDA and enter RD_ACK.
REQ-025 RD_ACK: sample SDA on 9th SCL rise; ACK (0) -> next byte in RD_BYTE; NACK (1) -> WAIT_STOP, SDA released.
REQ-026 WAIT_STOP: sda_oe=0, ignore bits until STOP or START.
REQ-027 cfg_reg changes only in WR_BYTE completion; a STOP or START mid-byte SHALL discard the partial byte with no cfg_wr.

Reset
REQ-028 On rst: state=IDLE, sda_oe=0, busy=0, cfg_wr=0, cfg_reg=CFG_RESET, bit counter=0, channel pointer=0, synchronizer flops=1.
REQ-029 rst asserted mid-transaction SHALL release SDA on the next clk edge; the block then ignores the bus until the next START.

Verification
REQ-030 Write 0x50 (addr 0x28,W), byte 0x30, STOP -> ACK on both 9th clocks, cfg_reg=0x30, single cfg_wr pulse, busy low after STOP.
REQ-031 cfg_reg=0x30, sample0=0x000, sample1=0xABC; read 0x51, 6 bytes ACK except last -> 0x1A,0xBC,0x00,0x00 wrong order rejected; required 0x00,0x00 for ch0 then 0x1A,0xBC for ch1 then 0x00,0x00 (wrap).
REQ-032 Address 0x29 write -> sda_oe never asserted, cfg_reg unchanged, busy drops on STOP.
REQ-033 cfg_reg=0x00, sample0=0xFFF; read two bytes -> 0x0F, 0xFF; NACK after byte1 -> SDA released, WAIT_STOP.
REQ-034 STOP issued after 4 bits of a config byte -> no cfg_wr, cfg_reg unchanged, state IDLE.
REQ-035 rst pulsed while sda_oe=1 during a read -> sda_oe=0 next cycle, cfg_reg=0x10, subsequent valid transaction ACKed normally.

Source files
------------

// File: rtl/ad2_i2c_responder.sv
// I2C target at a fixed 7-bit address.
// A write stores one configuration byte. A read streams 12-bit channel
// samples as two-byte words.
module ad2_i2c_responder #(
   parameter logic [6:0] I2C_ADDR  = 7'h28,
   parameter logic [7:0] CFG_RESET = 8'h10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   input  logic [11:0] sample0,
   input  logic [11:0] sample1,
   input  logic [11:0] sample2,
   input  logic [11:0] sample3,
   output logic [7:0]  cfg_reg,
   output logic        cfg_wr,
   output logic        busy
);

   localparam int unsigned SMP_W = 12;
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(7);
   localparam logic [CNT_W-1:0] BIT_DONE = CNT_W'(8);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
   } state_t;

   state_t           state;
   logic             scl_s1, scl_s2, scl_q;
   logic             sda_s1, sda_s2, sda_q;
   logic [CNT_W-1:0] bit_cnt;
   logic [7:0]       rx_sr;
   logic [7:0]       tx_sr;
   logic [SMP_W-1:0] val_q;
   logic [1:0]       ch_ptr;
   logic             rw;
   logic             byte_sel;
   logic             rd_ack;

   logic             scl_rise_c, scl_fall_c, start_c, stop_c;
   logic [7:0]       rx_next_c;
   logic [3:0]       active_c;
   logic [1:0]       lowest_c, next_c, load_ch_c;
   logic             found_c, load_b0_c;
   logic [SMP_W-1:0] load_smp_c;
   logic [7:0]       load_byte_c;

   // Two-flop synchronizers plus one history stage for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_s1 <= 1'b1;
         scl_s2 <= 1'b1;
         scl_q  <= 1'b1;
         sda_s1 <= 1'b1;
         sda_s2 <= 1'b1;
         sda_q  <= 1'b1;
      end else begin
         scl_s1 <= scl_in;
         scl_s2 <= scl_s1;
         scl_q  <= scl_s2;
         sda_s1 <= sda_in;
         sda_s2 <= sda_s1;
         sda_q  <= sda_s2;
      end
   end

   // Bus events seen on the synchronized lines
   always_comb begin
      scl_rise_c = scl_s2 & ~scl_q;
      scl_fall_c = ~scl_s2 & scl_q;
      start_c    = scl_s2 & scl_q & sda_q & ~sda_s2;
      stop_c     = scl_s2 & scl_q & ~sda_q & sda_s2;
      rx_next_c  = {rx_sr[6:0], sda_s2};
   end

   // Channel selection and next read byte
   always_comb begin
      active_c = (cfg_reg[7:4] == 4'h0) ? 4'b0001 : cfg_reg[7:4];
      lowest_c = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (active_c[i]) lowest_c = 2'(i);
      end
      next_c  = lowest_c;
      found_c = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (!found_c && (i > int'(ch_ptr)) && active_c[i]) begin
            next_c  = 2'(i);
            found_c = 1'b1;
         end
      end
      load_b0_c  = (state == ADDR_ACK) || !byte_sel;
      load_ch_c  = (state == ADDR_ACK) ? lowest_c : ch_ptr;
      load_smp_c = sample0;
      case (load_ch_c)
         2'd1:    load_smp_c = sample1;
         2'd2:    load_smp_c = sample2;
         2'd3:    load_smp_c = sample3;
         default: load_smp_c = sample0;
      endcase
      load_byte_c = load_b0_c ? {2'b00, load_ch_c, load_smp_c[11:8]} : val_q[7:0];
   end

   // Protocol FSM: bits sampled on SCL rise, SDA drive changes on SCL fall
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         sda_oe   <= 1'b0;
         busy     <= 1'b0;
         cfg_wr   <= 1'b0;
         cfg_reg  <= CFG_RESET;
         bit_cnt  <= CNT_W'(0);
         ch_ptr   <= 2'd0;
         rx_sr    <= 8'h00;
         tx_sr    <= 8'h00;
         val_q    <= SMP_W'(0);
         rw       <= 1'b0;
         byte_sel <= 1'b0;
         rd_ack   <= 1'b0;
      end else begin
         cfg_wr <= 1'b0;
         if (stop_c) begin
            state   <= IDLE;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            bit_cnt <= CNT_W'(0);
            rd_ack  <= 1'b0;
         end else if (start_c) begin
            state    <= ADDR;
            sda_oe   <= 1'b0;
            busy     <= 1'b1;
            bit_cnt  <= CNT_W'(0);
            byte_sel <= 1'b0;
            rd_ack   <= 1'b0;
         end else begin
            case (state)
               ADDR: if (scl_rise_c) begin
                  rx_sr <= rx_next_c;
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= CNT_W'(0);
                     if (rx_next_c[7:1] == I2C_ADDR) begin
                        state <= ADDR_ACK;
                        rw    <= rx_next_c[0];
                     end else begin
                        state <= WAIT_STOP;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
               // sda_oe doubles as the phase flag: low = before ACK, high = ACK clock
               ADDR_ACK: if (scl_fall_c) begin
                  if (!sda_oe) begin
                     sda_oe <= 1'b1;
                  end else if (rw) begin
                     state    <= RD_BYTE;
                     tx_sr    <= load_byte_c;
                     sda_oe   <= ~load_byte_c[7];
                     bit_cnt  <= CNT_W'(0);
                     val_q    <= load_smp_c;
                     ch_ptr   <= load_ch_c;
                     byte_sel <= 1'b1;
                  end else begin
                     sda_oe  <= 1'b0;
                     bit_cnt <= CNT_W'(0);
                     state   <= WR_BYTE;
                  end
               end
               WR_BYTE: if (scl_rise_c) begin
                  rx_sr <= rx_next_c;
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= CNT_W'(0);
                     cfg_reg <= rx_next_c;
                     cfg_wr  <= 1'b1;
                     state   <= WR_ACK;
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
               WR_ACK: if (scl_fall_c) begin
                  if (!sda_oe) begin
                     sda_oe <= 1'b1;
                  end else begin
                     sda_oe <= 1'b0;
                     state  <= WR_BYTE;
                  end
               end
               RD_BYTE: begin
                  if (scl_rise_c) begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end else if (scl_fall_c) begin
                     if (bit_cnt == BIT_DONE) begin
                        sda_oe  <= 1'b0;
                        bit_cnt <= CNT_W'(0);
                        state   <= RD_ACK;
                     end else begin
                        sda_oe <= ~tx_sr[6];
                        tx_sr  <= {tx_sr[6:0], 1'b0};
                     end
                  end
               end
               RD_ACK: begin
                  if (scl_rise_c) begin
                     if (!sda_s2) rd_ack <= 1'b1;
                     else         state  <= WAIT_STOP;
                  end else if (scl_fall_c && rd_ack) begin
                     rd_ack  <= 1'b0;
                     state   <= RD_BYTE;
                     tx_sr   <= load_byte_c;
                     sda_oe  <= ~load_byte_c[7];
                     bit_cnt <= CNT_W'(0);
                     if (load_b0_c) begin
                        val_q    <= load_smp_c;
                        ch_ptr   <= load_ch_c;
                        byte_sel <= 1'b1;
                     end else begin
                        ch_ptr   <= next_c;
                        byte_sel <= 1'b0;
                     end
                  end
               end
               default: sda_oe <= 1'b0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ad2_i2c_responder.sv
// Directed bench for ad2_i2c_responder: bit-banged I2C controller with a pull-up bus.
module tb_ad2_i2c_responder;

   localparam int unsigned Q = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic        scl;
   logic        sda_drv;
   logic        sda_bus;
   logic        sda_oe;
   logic [11:0] sample0, sample1, sample2, sample3;
   logic [7:0]  cfg_reg;
   logic        cfg_wr;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;
   int wr_pulses = 0;
   int oe_cycles = 0;

   typedef struct {
      logic [7:0]  cfg;
      logic [11:0] s0, s1, s2, s3;
      logic [7:0]  b0, b1;
   } vec_t;

   vec_t vecs [6];

   always #5 clk = ~clk;

   assign sda_bus = sda_drv & ~sda_oe;

   ad2_i2c_responder dut (
      .clk     (clk),
      .rst     (rst),
      .scl_in  (scl),
      .sda_in  (sda_bus),
      .sda_oe  (sda_oe),
      .sample0 (sample0),
      .sample1 (sample1),
      .sample2 (sample2),
      .sample3 (sample3),
      .cfg_reg (cfg_reg),
      .cfg_wr  (cfg_wr),
      .busy    (busy)
   );

   // Running counts of write pulses and SDA-drive cycles
   always @(posedge clk) begin
      if (cfg_wr) wr_pulses <= wr_pulses + 1;
      if (sda_oe) oe_cycles <= oe_cycles + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic qwait();
      repeat (Q) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_drv = 1'b1; qwait();
      scl = 1'b1;     qwait();
      sda_drv = 1'b0; qwait();
      scl = 1'b0;     qwait();
   endtask

   task automatic i2c_stop();
      sda_drv = 1'b0; qwait();
      scl = 1'b1;     qwait();
      sda_drv = 1'b1; qwait();
   endtask

   task automatic write_bit(input logic b);
      sda_drv = b; qwait();
      scl = 1'b1;  qwait(); qwait();
      scl = 1'b0;  qwait();
   endtask

   task automatic send_byte(input logic [7:0] b, output logic acked);
      for (int i = 7; i >= 0; i--) write_bit(b[i]);
      sda_drv = 1'b1; qwait();
      scl = 1'b1;     qwait();
      acked = ~sda_bus;
      qwait();
      scl = 1'b0;     qwait();
   endtask

   task automatic recv_byte(input logic ack, output logic [7:0] d);
      for (int i = 7; i >= 0; i--) begin
         sda_drv = 1'b1; qwait();
         scl = 1'b1;     qwait();
         d[i] = sda_bus;
         qwait();
         scl = 1'b0;     qwait();
      end
      sda_drv = ~ack; qwait();
      scl = 1'b1;     qwait(); qwait();
      scl = 1'b0;
      @(negedge clk); @(negedge clk);
      sda_drv = 1'b1; qwait();
   endtask

   initial begin
      logic       a;
      logic [7:0] d;
      int         w0;
      int         o0;
      logic [7:0] exp6 [6];

      vecs[0] = '{cfg: 8'h00, s0: 12'hFFF, s1: 12'h111, s2: 12'h222, s3: 12'h333, b0: 8'h0F, b1: 8'hFF};
      vecs[1] = '{cfg: 8'h30, s0: 12'h000, s1: 12'hABC, s2: 12'h222, s3: 12'h333, b0: 8'h00, b1: 8'h00};
      vecs[2] = '{cfg: 8'h20, s0: 12'h456, s1: 12'hABC, s2: 12'h222, s3: 12'h333, b0: 8'h1A, b1: 8'hBC};
      vecs[3] = '{cfg: 8'h80, s0: 12'h456, s1: 12'h111, s2: 12'h222, s3: 12'h5A3, b0: 8'h35, b1: 8'hA3};
      vecs[4] = '{cfg: 8'hC0, s0: 12'h456, s1: 12'h111, s2: 12'h123, s3: 12'h777, b0: 8'h21, b1: 8'h23};
      vecs[5] = '{cfg: 8'h1F, s0: 12'h800, s1: 12'h111, s2: 12'h222, s3: 12'h333, b0: 8'h08, b1: 8'h00};

      rst = 1'b1; scl = 1'b1; sda_drv = 1'b1;
      sample0 = 12'h000; sample1 = 12'h000; sample2 = 12'h000; sample3 = 12'h000;
      repeat (4) @(negedge clk);
      check("rst_sda_oe", 32'(sda_oe), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_cfg_wr", 32'(cfg_wr), 32'(0));
      check("rst_cfg_reg", 32'(cfg_reg), 32'h10);
      rst = 1'b0;
      qwait();

      // Configuration write of 0x30
      w0 = wr_pulses;
      i2c_start();
      check("wr_busy_after_start", 32'(busy), 32'(1));
      send_byte(8'h50, a);  check("wr_addr_ack", 32'(a), 32'(1));
      send_byte(8'h30, a);  check("wr_data_ack", 32'(a), 32'(1));
      i2c_stop();
      check("wr_cfg_reg", 32'(cfg_reg), 32'h30);
      check("wr_cfg_wr_pulses", 32'(wr_pulses - w0), 32'(1));
      check("wr_busy_after_stop", 32'(busy), 32'(0));

      // Six-byte read over channels 0 and 1 with wrap
      sample0 = 12'h000; sample1 = 12'hABC; sample2 = 12'h222; sample3 = 12'h333;
      exp6[0] = 8'h00; exp6[1] = 8'h00; exp6[2] = 8'h1A;
      exp6[3] = 8'hBC; exp6[4] = 8'h00; exp6[5] = 8'h00;
      i2c_start();
      send_byte(8'h51, a);  check("rd6_addr_ack", 32'(a), 32'(1));
      for (int k = 0; k < 6; k++) begin
         recv_byte(k != 5, d);
         check($sformatf("rd6_byte%0d", k), 32'(d), 32'(exp6[k]));
      end
      check("rd6_released", 32'(sda_oe), 32'(0));
      i2c_stop();
      check("rd6_busy", 32'(busy), 32'(0));

      // Foreign address 0x29: never driven, config untouched
      o0 = oe_cycles; w0 = wr_pulses;
      i2c_start();
      send_byte(8'h52, a);  check("nack_addr", 32'(a), 32'(0));
      send_byte(8'h77, a);  check("nack_data", 32'(a), 32'(0));
      check("nack_busy_before_stop", 32'(busy), 32'(1));
      i2c_stop();
      check("nack_oe_cycles", 32'(oe_cycles - o0), 32'(0));
      check("nack_cfg_reg", 32'(cfg_reg), 32'h30);
      check("nack_no_wr", 32'(wr_pulses - w0), 32'(0));
      check("nack_busy_after_stop", 32'(busy), 32'(0));

      // STOP after four bits of a data byte discards it
      w0 = wr_pulses;
      i2c_start();
      send_byte(8'h50, a);  check("part_addr_ack", 32'(a), 32'(1));
      write_bit(1'b1); write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
      i2c_stop();
      check("part_no_wr", 32'(wr_pulses - w0), 32'(0));
      check("part_cfg_reg", 32'(cfg_reg), 32'h30);
      check("part_busy", 32'(busy), 32'(0));
      check("part_sda_oe", 32'(sda_oe), 32'(0));

      // Repeated START mid-byte, then a full write
      w0 = wr_pulses;
      i2c_start();
      send_byte(8'h50, a);
      write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
      i2c_start();
      check("rs_busy", 32'(busy), 32'(1));
      send_byte(8'h50, a);  check("rs_addr_ack", 32'(a), 32'(1));
      send_byte(8'h44, a);  check("rs_data_ack", 32'(a), 32'(1));
      i2c_stop();
      check("rs_one_wr", 32'(wr_pulses - w0), 32'(1));
      check("rs_cfg_reg", 32'(cfg_reg), 32'h44);

      // Table: configure, then read the first word and NACK
      for (int k = 0; k < 6; k++) begin
         sample0 = vecs[k].s0; sample1 = vecs[k].s1;
         sample2 = vecs[k].s2; sample3 = vecs[k].s3;
         w0 = wr_pulses;
         i2c_start();
         send_byte(8'h50, a);        check($sformatf("v%0d_wr_addr_ack", k), 32'(a), 32'(1));
         send_byte(vecs[k].cfg, a);  check($sformatf("v%0d_wr_data_ack", k), 32'(a), 32'(1));
         i2c_stop();
         check($sformatf("v%0d_cfg_reg", k), 32'(cfg_reg), 32'(vecs[k].cfg));
         check($sformatf("v%0d_cfg_wr", k), 32'(wr_pulses - w0), 32'(1));
         i2c_start();
         send_byte(8'h51, a);        check($sformatf("v%0d_rd_addr_ack", k), 32'(a), 32'(1));
         recv_byte(1'b1, d);         check($sformatf("v%0d_byte0", k), 32'(d), 32'(vecs[k].b0));
         recv_byte(1'b0, d);         check($sformatf("v%0d_byte1", k), 32'(d), 32'(vecs[k].b1));
         repeat (4) @(negedge clk);
         check($sformatf("v%0d_nack_released", k), 32'(sda_oe), 32'(0));
         check($sformatf("v%0d_wait_busy", k), 32'(busy), 32'(1));
         i2c_stop();
         check($sformatf("v%0d_idle_busy", k), 32'(busy), 32'(0));
      end

      // Reset while driving SDA during a read
      sample0 = 12'h000;
      i2c_start();
      send_byte(8'h51, a);  check("rr_addr_ack", 32'(a), 32'(1));
      check("rr_driving", 32'(sda_oe), 32'(1));
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check("rr_released_next", 32'(sda_oe), 32'(0));
      @(negedge clk); rst = 1'b0;
      check("rr_cfg_reset", 32'(cfg_reg), 32'h10);
      check("rr_busy", 32'(busy), 32'(0));
      i2c_stop();
      w0 = wr_pulses;
      i2c_start();
      send_byte(8'h50, a);  check("rr_wr_addr_ack", 32'(a), 32'(1));
      send_byte(8'h66, a);  check("rr_wr_data_ack", 32'(a), 32'(1));
      i2c_stop();
      check("rr_cfg_reg", 32'(cfg_reg), 32'h66);
      check("rr_cfg_wr", 32'(wr_pulses - w0), 32'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
